writeback_reg: RTL

//  MEM->WB pipeline register plus load-data formatter. Captures memory-stage results each

---
 rtl/writeback_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/writeback_reg.sv
// MEM->WB pipeline register with sub-word load formatting; 1-cycle latency; stall_hold freezes all state, stall_m or flush inserts a bubble.
// Optional WB_PERF_CNT_EN adds 64-bit retired/bubble counters (tied to 0 otherwise).
module writeback_reg #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_wa,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_result_alu,
    input  logic [XLEN-1:0] in_rdata,
    input  logic            stall_m,
    input  logic            stall_hold,
    input  logic            flush,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [RA_W-1:0] wb_wa,
    output logic            wb_regwrite,
    output logic [XLEN-1:0] wb_wd,
    output logic [RA_W-1:0] fwd_wa,
    output logic            fwd_regwrite,
    output logic [XLEN-1:0] fwd_result,
    output logic [63:0]     perf_retired,
    output logic [63:0]     perf_bubbles
);

    logic [2:0]      laneOff;
    logic [XLEN-1:0] laneData;
    logic [XLEN-1:0] fmtData;
    logic [XLEN-1:0] nextWd;
    logic            signExt;

    // Misaligned low address bits are dropped by masking to the access size.
    always_comb begin
        laneOff = 3'd0;
        case (in_size)
            2'd0:    laneOff = in_addr_lo;
            2'd1:    laneOff = {in_addr_lo[2:1], 1'b0};
            2'd2:    laneOff = {in_addr_lo[2], 2'b00};
            default: laneOff = 3'd0;
        endcase
    end

    assign laneData = in_rdata >> {laneOff, 3'b000};
    assign signExt  = ~in_unsigned;

    always_comb begin
        fmtData = laneData;
        case (in_size)
            2'd0:    fmtData = {{(XLEN-8){signExt & laneData[7]}}, laneData[7:0]};
            2'd1:    fmtData = {{(XLEN-16){signExt & laneData[15]}}, laneData[15:0]};
            2'd2:    fmtData = {{(XLEN-32){signExt & laneData[31]}}, laneData[31:0]};
            default: fmtData = laneData;
        endcase
    end

    assign nextWd = in_memread ? fmtData : in_result_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_pc       <= '0;
            wb_wa       <= '0;
            wb_regwrite <= 1'b0;
            wb_wd       <= '0;
        end else if (!stall_hold) begin
            if (flush || stall_m) begin
                wb_valid    <= 1'b0;
                wb_pc       <= '0;
                wb_wa       <= '0;
                wb_regwrite <= 1'b0;
                wb_wd       <= '0;
            end else begin
                wb_valid    <= in_valid;
                wb_pc       <= in_pc;
                wb_wa       <= in_wa;
                wb_regwrite <= in_valid & in_regwrite & (in_wa != '0);
                wb_wd       <= nextWd;
            end
        end
    end

    assign fwd_wa       = wb_wa;
    assign fwd_regwrite = wb_regwrite;
    assign fwd_result   = wb_wd;

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired <= '0;
            perf_bubbles <= '0;
        end else if (!stall_hold) begin
            if (wb_valid) begin
                perf_retired <= perf_retired + 64'd1;
            end
            if (stall_m && !flush) begin
                perf_bubbles <= perf_bubbles + 64'd1;
            end
        end
    end
`else
    assign perf_retired = 64'd0;
    assign perf_bubbles = 64'd0;
`endif

endmodule
